// File: rtl/leaky_relu_arbiter.sv
// Round-robin arbiter feeding one shared leaky-ReLU stage; owns the leak-factor register.
// Optional stats ports (neg_count, last_grant) are built when LEAKY_RELU_ARBITER_STATS_EN is defined.
module leaky_relu_arbiter #(
  parameter int NUM_COLS  = 4,
  parameter int FRAC_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_COLS-1:0]         req_valid,
  input  logic [16*NUM_COLS-1:0]      req_data,
  output logic [NUM_COLS-1:0]         req_ready,
  input  logic                        leak_load,
  input  logic [15:0]                 leak_factor_in,
  output logic [15:0]                 leak_factor,
  output logic                        out_valid,
  output logic [15:0]                 out_data,
  output logic [$clog2(NUM_COLS)-1:0] out_col,
  input  logic                        out_ready,
  output logic                        busy
`ifdef LEAKY_RELU_ARBITER_STATS_EN
  ,
  output logic [31:0]                 neg_count,
  output logic [NUM_COLS-1:0]         last_grant
`endif
);

  // state         | meaning
  // EMPTY         | out_valid=0, stage accepts
  // FULL_DRAINING | out_valid=1 and out_ready=1, stage accepts
  // STALLED       | out_valid=1 and out_ready=0, no grant
  localparam int CW = $clog2(NUM_COLS);

  logic [CW-1:0]       r_ptr;
  logic [15:0]         r_leak;
  logic                r_out_valid;
  logic [15:0]         r_out_data;
  logic [CW-1:0]       r_out_col;

  logic                w_can_accept;
  logic [NUM_COLS-1:0] w_grant;
  logic [CW-1:0]       w_gidx;
  logic                w_found;
  logic                w_xfer;
  logic [15:0]         w_x;
  logic signed [31:0]  w_prod;
  logic [15:0]         w_shift;
  logic [15:0]         w_res;

  assign w_can_accept = !r_out_valid || out_ready;

  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int j = 0; j < NUM_COLS; j++) begin
      idx = (int'(r_ptr) + j) % NUM_COLS;
      if (!w_found && req_valid[idx]) begin
        w_found      = 1'b1;
        w_gidx       = CW'(idx);
        w_grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready = w_can_accept ? w_grant : '0;
  assign w_xfer    = |req_ready;

  // Product is widened to 32 bits before multiply so the floor shift sees the full result.
  assign w_x     = req_data[16*int'(w_gidx) +: 16];
  assign w_prod  = $signed({{16{w_x[15]}}, w_x}) * $signed({{16{r_leak[15]}}, r_leak});
  assign w_shift = 16'(w_prod >>> FRAC_BITS);
  assign w_res   = (!w_x[15] && (w_x != 16'd0)) ? w_x : w_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_leak      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
    end else begin
      if (leak_load)
        r_leak <= leak_factor_in;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_col   <= w_gidx;
        r_ptr       <= (w_gidx == CW'(NUM_COLS-1)) ? '0 : w_gidx + 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef LEAKY_RELU_ARBITER_STATS_EN
  logic [31:0]         r_neg_count;
  logic [NUM_COLS-1:0] r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_count  <= '0;
      r_last_grant <= '0;
    end else if (w_xfer) begin
      r_last_grant <= req_ready;
      if (w_x[15])
        r_neg_count <= r_neg_count + 32'd1;
    end
  end

  assign neg_count  = r_neg_count;
  assign last_grant = r_last_grant;
`else
  // Stats disabled: no extra state.
`endif

  assign leak_factor = r_leak;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_col     = r_out_col;
  assign busy        = r_out_valid || (|req_valid);

endmodule

// File: doc/leaky_relu_arbiter.md
Name: leaky_relu_arbiter

Overview:
Shares one leaky-ReLU activation datapath between NUM_COLS systolic-array column outputs.
- Arbitration: round-robin across columns; each column presents a valid/ready stream.
- Datapath: signed fixed-point leaky-ReLU, one registered output stage.
- Output: one valid/ready stream tagged with the source column index.
- Also owns the runtime leak-factor configuration register.
- Sits between the systolic array drain and the unified buffer write path.

Parameters:
- NUM_COLS, 4, number of requesting columns (≥2).
- FRAC_BITS, 8, fractional bits of the signed Q(16-FRAC_BITS).FRAC_BITS format used for data and leak factor.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  NUM_COLS  per-column sample valid
- req_data  input  16*NUM_COLS  per-column signed sample; column i occupies bits [16i+15:16i]
- req_ready  output  NUM_COLS  per-column accept; one-hot or zero
- leak_load  input  1  load leak_factor_in into config register
- leak_factor_in  input  16  new signed leak factor
- leak_factor  output  16  current leak factor register
- out_valid  output  1  result valid
- out_data  output  16  activated result
- out_col  output  $clog2(NUM_COLS)  source column of out_data
- out_ready  input  1  downstream accept
- busy  output  1  out_valid OR any req_valid

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Registers: out_valid=0, out_data=0, out_col=0, leak_factor=0 (plain ReLU), rr pointer=0.
  - req_ready is combinational and therefore 0 while out_valid=0 and no req_valid is asserted.
  - Reset mid-transfer drops the held output without handshake.
- Transfer: a transfer on column i occurs when req_valid[i] && req_ready[i]. At most one transfer per cycle.
- Output stage "can accept" = !out_valid || out_ready.
- Grant:
  - When the stage can accept, grant the first requesting column at or after the rr pointer, scanning upward with wrap.
  - req_ready is high only for the granted column.
  - If the stage cannot accept, req_ready=0.
  - Grant is combinational from req_valid, the pointer and the stage state; there is no combinational path from req_data.
- Pointer: after a transfer on column g, pointer = (g+1) mod NUM_COLS; otherwise unchanged.
- Latency: a transfer in cycle N gives out_valid=1 in cycle N+1 with out_data and out_col=g.
  - Back-to-back: one result per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, out_data and out_col hold.
  - If the output is consumed in the same cycle as a new transfer, the new result replaces it (full throughput).
- Arithmetic, with x = sample and k = leak_factor:
  - x > 0: out = x.
  - x ≤ 0: out = low 16 bits of ((x*k) >>> FRAC_BITS), computed on the signed 32-bit product, arithmetic shift (floor).
  - x = 0 gives 0.
  - No saturation; |k| ≤ 1.0 is the caller's contract.
- Config:
  - leak_load updates leak_factor on the next edge.
  - A transfer in the same cycle uses the old factor.
  - Loads are legal at any time, and leak_factor is held until the next load.
- States (derived from out_valid and out_ready):
  - EMPTY (out_valid=0).
  - FULL_DRAINING (out_valid && out_ready).
  - STALLED (out_valid && !out_ready); no grant in this state.
  - EMPTY→FULL on transfer. FULL→EMPTY on consume with no transfer. STALLED→FULL_DRAINING when out_ready rises.
- Starvation: a column holding req_valid is granted within NUM_COLS transfers.

Optional Feature:
- Macro: LEAKY_RELU_ARBITER_STATS_EN.
- Defined:
  - Adds output neg_count (32 bits): the number of transfers with x < 0. x = 0 is not counted.
  - Reset value 0; increments on each such transfer; wraps at 2^32.
  - Adds output last_grant (NUM_COLS bits): one-hot of the most recent transfer, reset 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Leak factor k=0x0080 (0.5). Column 0 sends 0xFE00 → next cycle out_data=0xFF00, out_col=0. Column 0 sends 0x0300 → 0x0300. Column 0 sends 0xFFFF → 0xFFFF (floor). Column 0 sends 0x0000 → 0x0000.
- All 4 columns hold valid with out_ready=1 → out_col sequence 0,1,2,3,0,…; one result per cycle; each req_ready is asserted once per 4 cycles.
- out_ready low for 3 cycles with columns requesting → req_ready=0. out_data/out_col stable. No sample is lost. Order resumes from the pointer.
- Pulse leak_load=1 with leak_factor_in=0x0040 in the same cycle column 2 transfers 0xFF00 → that result is 0xFF80 (k=0.5). The next transfer of 0xFF00 gives 0xFFC0.
- After reset, a negative sample with no leak load → 0x0000. Asserting rst while STALLED → out_valid=0 next cycle and the pointer is back at 0.
- With LEAKY_RELU_ARBITER_STATS_EN: transfers of 0xFF00, 0x0100, 0x0000, 0x8000 → neg_count=2; last_grant matches the final column.
